// File: rtl/bet_entry.sv
// Bet entry controller: accepts a wager, locks it for one round, then commits the
// settled balance from the balance-update logic and tracks errors and round count.
module bet_entry #(
    parameter logic [7:0] INIT_BALANCE = 8'd100
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       bet_valid,
    input  logic [1:0] bettype_in,
    input  logic [7:0] betamount_in,
    input  logic       round_done,
    input  logic [7:0] newbalance,
    input  logic       moneyerr,
    output logic [1:0] currentbettype,
    output logic [7:0] currentbetamount,
    output logic [7:0] currentbalance,
    output logic       round_start,
    output logic       bet_reject,
    output logic       err_sticky,
    output logic       broke,
    output logic [7:0] rounds
);

    typedef enum logic [1:0] {StIdle, StLocked, StCommit, StBroke} state_e;

    state_e     state_q;
    logic [7:0] held_balance_q;
    logic       held_err_q;
    logic       bet_ok;
    logic [7:0] commit_balance;

    always_comb begin
        bet_ok = (bettype_in != 2'b00) && (betamount_in != 8'd0) &&
                 (betamount_in <= currentbalance);
        // An errored settlement keeps the old balance; BROKE is decided on this value.
        commit_balance = held_err_q ? currentbalance : held_balance_q;
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q          <= StIdle;
            currentbalance   <= INIT_BALANCE;
            currentbettype   <= 2'b00;
            currentbetamount <= 8'd0;
            round_start      <= 1'b0;
            bet_reject       <= 1'b0;
            err_sticky       <= 1'b0;
            broke            <= 1'b0;
            rounds           <= 8'd0;
            held_balance_q   <= 8'd0;
            held_err_q       <= 1'b0;
        end else begin
            round_start <= 1'b0;
            bet_reject  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bet_valid) begin
                        if (bet_ok) begin
                            currentbettype   <= bettype_in;
                            currentbetamount <= betamount_in;
                            round_start      <= 1'b1;
                            state_q          <= StLocked;
                        end else begin
                            bet_reject <= 1'b1;
                        end
                    end
                end
                StLocked: begin
                    if (round_done) begin
                        held_balance_q <= newbalance;
                        held_err_q     <= moneyerr;
                        state_q        <= StCommit;
                    end
                end
                StCommit: begin
                    currentbalance <= commit_balance;
                    if (held_err_q) begin
                        err_sticky <= 1'b1;
                    end
                    if (rounds != 8'd255) begin
                        rounds <= rounds + 8'd1;
                    end
                    if (commit_balance == 8'd0) begin
                        state_q <= StBroke;
                        broke   <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBroke: begin
                    broke <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bet_entry.sv
// Directed bench for bet_entry: a behavioural model pushes expected outputs to a
// scoreboard each cycle; they are popped and compared one edge later.
module tb_bet_entry;

    logic       slow_clock;
    logic       resetb;
    logic       bet_valid;
    logic [1:0] bettype_in;
    logic [7:0] betamount_in;
    logic       round_done;
    logic [7:0] newbalance;
    logic       moneyerr;
    logic [1:0] currentbettype;
    logic [7:0] currentbetamount;
    logic [7:0] currentbalance;
    logic       round_start;
    logic       bet_reject;
    logic       err_sticky;
    logic       broke;
    logic [7:0] rounds;

    bet_entry dut (
        .slow_clock      (slow_clock),
        .resetb          (resetb),
        .bet_valid       (bet_valid),
        .bettype_in      (bettype_in),
        .betamount_in    (betamount_in),
        .round_done      (round_done),
        .newbalance      (newbalance),
        .moneyerr        (moneyerr),
        .currentbettype  (currentbettype),
        .currentbetamount(currentbetamount),
        .currentbalance  (currentbalance),
        .round_start     (round_start),
        .bet_reject      (bet_reject),
        .err_sticky      (err_sticky),
        .broke           (broke),
        .rounds          (rounds)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    typedef struct packed {
        logic [1:0] bt;
        logic [7:0] ba;
        logic [7:0] bal;
        logic       rs;
        logic       rj;
        logic       err;
        logic       brk;
        logic [7:0] rnd;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int passed = 0;

    // Reference model state: 0 idle, 1 locked, 2 commit, 3 broke.
    int         m_state;
    logic [1:0] m_type;
    logic [7:0] m_amt;
    logic [7:0] m_bal;
    logic       m_err;
    logic [7:0] m_rounds;
    logic [7:0] m_hb;
    logic       m_he;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_type   = 2'b00;
        m_amt    = 8'd0;
        m_bal    = 8'd100;
        m_err    = 1'b0;
        m_rounds = 8'd0;
        m_hb     = 8'd0;
        m_he     = 1'b0;
        sb.delete();
    endtask

    task automatic step(input logic bv, input logic [1:0] bt, input logic [7:0] ba,
                        input logic rd, input logic [7:0] nb, input logic me);
        exp_t e;
        logic rs;
        logic rj;
        bet_valid    = bv;
        bettype_in   = bt;
        betamount_in = ba;
        round_done   = rd;
        newbalance   = nb;
        moneyerr     = me;
        rs = 1'b0;
        rj = 1'b0;
        case (m_state)
            0: if (bv) begin
                if (bt != 2'b00 && ba != 8'd0 && ba <= m_bal) begin
                    m_type  = bt;
                    m_amt   = ba;
                    m_state = 1;
                    rs      = 1'b1;
                end else begin
                    rj = 1'b1;
                end
            end
            1: if (rd) begin
                m_hb    = nb;
                m_he    = me;
                m_state = 2;
            end
            2: begin
                if (m_he) m_err = 1'b1;
                else m_bal = m_hb;
                if (m_rounds < 8'd255) m_rounds = m_rounds + 8'd1;
                m_state = (m_bal == 8'd0) ? 3 : 0;
            end
            default: ;
        endcase
        e = '{bt: m_type, ba: m_amt, bal: m_bal, rs: rs, rj: rj, err: m_err,
              brk: (m_state == 3), rnd: m_rounds};
        sb.push_back(e);
        @(posedge slow_clock);
        #1;
        bet_valid  = 1'b0;
        round_done = 1'b0;
        checks++;
        assert (sb.size() != 0) passed++;
        else $error("FAIL sb_empty: observed 0 entries expected 1");
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("bettype", {6'd0, currentbettype}, {6'd0, e.bt});
            chk("betamount", currentbetamount, e.ba);
            chk("balance", currentbalance, e.bal);
            chk("round_start", {7'd0, round_start}, {7'd0, e.rs});
            chk("bet_reject", {7'd0, bet_reject}, {7'd0, e.rj});
            chk("err_sticky", {7'd0, err_sticky}, {7'd0, e.err});
            chk("broke", {7'd0, broke}, {7'd0, e.brk});
            chk("rounds", rounds, e.rnd);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_bal"}, currentbalance, 8'd100);
        chk({tag, "_type"}, {6'd0, currentbettype}, 8'd0);
        chk({tag, "_amt"}, currentbetamount, 8'd0);
        chk({tag, "_rs"}, {7'd0, round_start}, 8'd0);
        chk({tag, "_rj"}, {7'd0, bet_reject}, 8'd0);
        chk({tag, "_err"}, {7'd0, err_sticky}, 8'd0);
        chk({tag, "_broke"}, {7'd0, broke}, 8'd0);
        chk({tag, "_rounds"}, rounds, 8'd0);
    endtask

    initial begin
        resetb       = 1'b0;
        bet_valid    = 1'b0;
        bettype_in   = 2'b00;
        betamount_in = 8'd0;
        round_done   = 1'b0;
        newbalance   = 8'd0;
        moneyerr     = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        resetb = 1'b1;

        // Rejects at balance 100: zero amount, over-balance, illegal type.
        step(1'b1, 2'b01, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("rej_zero", {7'd0, bet_reject}, 8'd1);
        step(1'b1, 2'b01, 8'd101, 1'b0, 8'd0, 1'b0);
        chk("rej_over", {7'd0, bet_reject}, 8'd1);
        step(1'b1, 2'b00, 8'd10, 1'b0, 8'd0, 1'b0);
        chk("rej_type", {7'd0, bet_reject}, 8'd1);
        step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0);

        // Basic round; round_done arrives in the round_start cycle.
        step(1'b1, 2'b01, 8'd20, 1'b0, 8'd0, 1'b0);
        chk("basic_rs", {7'd0, round_start}, 8'd1);
        step(1'b0, 2'b00, 8'd0, 1'b1, 8'd120, 1'b0);
        chk("basic_bal_pending", currentbalance, 8'd100);
        step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("basic_bal", currentbalance, 8'd120);
        chk("basic_rounds", rounds, 8'd1);

        // Stray round_done in IDLE, stray bet_valid in LOCKED.
        step(1'b0, 2'b00, 8'd0, 1'b1, 8'd7, 1'b0);
        step(1'b1, 2'b10, 8'd30, 1'b0, 8'd0, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0);
        step(1'b1, 2'b01, 8'd5, 1'b0, 8'd0, 1'b0);
        chk("locked_type_hold", {6'd0, currentbettype}, 8'd2);
        step(1'b0, 2'b00, 8'd0, 1'b1, 8'd90, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("stray_bal", currentbalance, 8'd90);

        // Settlement error, then a clean round; err_sticky must persist.
        step(1'b1, 2'b11, 8'd10, 1'b0, 8'd0, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b1, 8'd255, 1'b1);
        step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("err_bal", currentbalance, 8'd90);
        chk("err_set", {7'd0, err_sticky}, 8'd1);
        step(1'b1, 2'b01, 8'd90, 1'b0, 8'd0, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b1, 8'd180, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("err_keep", {7'd0, err_sticky}, 8'd1);

        // Mid-round reset in LOCKED abandons the round immediately.
        step(1'b1, 2'b01, 8'd10, 1'b0, 8'd0, 1'b0);
        resetb = 1'b0;
        #1;
        check_reset_values("midrst");
        resetb = 1'b1;
        #1;
        model_reset();
        step(1'b1, 2'b10, 8'd100, 1'b0, 8'd0, 1'b0);
        chk("post_rst_accept", {7'd0, round_start}, 8'd1);
        step(1'b0, 2'b00, 8'd0, 1'b1, 8'd100, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0);

        // Round counter saturation.
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 2'b01, 8'd1, 1'b0, 8'd0, 1'b0);
            step(1'b0, 2'b00, 8'd0, 1'b1, 8'd100, 1'b0);
            step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0);
        end
        chk("rounds_sat", rounds, 8'd255);

        // All-in loss to BROKE; further requests ignored without reject.
        step(1'b1, 2'b10, 8'd100, 1'b0, 8'd0, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b1, 8'd0, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("broke_set", {7'd0, broke}, 8'd1);
        chk("broke_bal", currentbalance, 8'd0);
        step(1'b1, 2'b01, 8'd1, 1'b0, 8'd0, 1'b0);
        chk("broke_norej", {7'd0, bet_reject}, 8'd0);
        step(1'b0, 2'b00, 8'd0, 1'b1, 8'd50, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("broke_hold", {7'd0, broke}, 8'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
